pipe_reg_elastic: RTL and testbench



---
 rtl/pipe_reg_elastic.sv | 89 ++++++++
 tb/tb_pipe_reg_elastic.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_elastic.sv
// pipe_reg_elastic: elastic multi-stage pipeline register with valid/ready backpressure,
// per-stage bubble collapse, synchronous flush and a registered occupancy count. Rev 1.0
`default_nettype none

module pipe_reg_elastic #(
  parameter int               WIDTH     = 32,
  parameter int               STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [$clog2(STAGES+1)-1:0]   count
);

  localparam int CW = $clog2(STAGES+1);

  logic [STAGES-1:0] v;
  logic [WIDTH-1:0]  d     [STAGES];
  logic [STAGES-1:0] ld;
  logic [STAGES-1:0] src_v;
  logic [WIDTH-1:0]  src_d [STAGES];
  logic              in_fire;
  logic              out_fire;

  // A stage can load unless it and every stage after it is full while the
  // output is stalled; written in closed form so the ready chain has no loop.
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    assign ld[i] = out_ready || !(&v[STAGES-1:i]);
    if (i == 0) begin : g_first
      assign src_v[i] = in_valid;
      assign src_d[i] = in_data;
    end else begin : g_next
      assign src_v[i] = v[i-1];
      assign src_d[i] = d[i-1];
    end
  end

  assign in_ready  = ld[0] && !flush;
  assign out_valid = v[STAGES-1];
  assign out_data  = d[STAGES-1];
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int i = 0; i < STAGES; i++) begin
        d[i] <= RESET_VAL;
      end
    end else if (flush) begin
      v <= '0;
      for (int i = 0; i < STAGES; i++) begin
        d[i] <= RESET_VAL;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (ld[i]) begin
          v[i] <= src_v[i];
          // Payload only moves with a valid so an idle stage keeps its last value.
          if (src_v[i]) begin
            d[i] <= src_d[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (in_fire && !out_fire) begin
      count <= count + CW'(1);
    end else if (!in_fire && out_fire) begin
      count <= count - CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipe_reg_elastic.sv
// tb_pipe_reg_elastic: table-driven vectors with a payload scoreboard for pipe_reg_elastic.
`default_nettype none

module tb_pipe_reg_elastic;

  localparam int          WIDTH  = 32;
  localparam int          STAGES = 3;
  localparam int          CW     = $clog2(STAGES+1);
  localparam logic [31:0] RST_V  = 32'h0BAD_F00D;
  localparam logic [31:0] JUNK   = 32'hFFFF_A5A5;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;

  pipe_reg_elastic #(.WIDTH(WIDTH), .STAGES(STAGES), .RESET_VAL(RST_V)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          iv;
    logic [31:0] data;
    bit          ordy;
    bit          fl;
    bit          e_ir;
    bit          e_ov;
    int          e_cnt;
    bit          e_rst;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb[$];
  int          total;
  int          bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void add(input bit iv, input logic [31:0] dat, input bit ordy, input bit fl,
                              input bit eir, input bit eov, input int ecnt, input bit erst = 1'b0);
    vec_t t;
    t.iv = iv; t.data = dat; t.ordy = ordy; t.fl = fl;
    t.e_ir = eir; t.e_ov = eov; t.e_cnt = ecnt; t.e_rst = erst;
    vecs.push_back(t);
  endfunction

  task automatic apply(input vec_t t);
    logic [31:0] exp;
    @(negedge clk);
    in_valid  = t.iv;
    in_data   = t.data;
    out_ready = t.ordy;
    flush     = t.fl;
    #1;
    chk("in_ready", 32'(in_ready), 32'(t.e_ir));
    chk("out_valid", 32'(out_valid), 32'(t.e_ov));
    chk("count", 32'(count), 32'(t.e_cnt));
    if (t.e_rst) chk("out_data_reset", out_data, RST_V);
    if (t.e_ov && t.ordy) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_empty actual=%h required=none", out_data);
      end else begin
        exp = sb.pop_front();
        chk("out_data", out_data, exp);
      end
    end
    if (t.fl) sb.delete();
    if (t.iv && t.e_ir) sb.push_back(t.data);
    @(posedge clk);
  endtask

  task automatic run_vecs();
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);
    vecs.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_data", out_data, RST_V);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_in_ready", 32'(in_ready), 32'd1);

    // stream 16 payloads at full rate, then drain
    for (int k = 0; k < 16; k++) add(1, 32'(k + 1), 1, 0, 1, k >= 3, (k < 3) ? k : 3);
    add(0, JUNK, 1, 0, 1, 1, 3); add(0, JUNK, 1, 0, 1, 1, 2);
    add(0, JUNK, 1, 0, 1, 1, 1); add(0, JUNK, 1, 0, 1, 0, 0);
    // backpressure fill, full blocks input, then drain
    add(1, 32'hA, 0, 0, 1, 0, 0); add(1, 32'hB, 0, 0, 1, 0, 1); add(1, 32'hC, 0, 0, 1, 0, 2);
    add(1, 32'hD, 0, 0, 0, 1, 3);
    add(0, JUNK, 1, 0, 1, 1, 3); add(0, JUNK, 1, 0, 1, 1, 2); add(0, JUNK, 1, 0, 1, 1, 1);
    add(0, JUNK, 1, 0, 1, 0, 0);
    // bubble collapse under a stalled output
    add(1, 32'h5, 0, 0, 1, 0, 0); add(0, JUNK, 0, 0, 1, 0, 1); add(1, 32'h6, 0, 0, 1, 0, 1);
    add(0, JUNK, 0, 0, 1, 1, 2); add(0, JUNK, 0, 0, 1, 1, 2);
    // flush with an offered input; idle junk must not disturb the reset payload
    add(1, 32'h77, 0, 1, 0, 1, 2);
    for (int k = 0; k < 4; k++) add(0, JUNK, 1, 0, 1, 0, 0, 1);
    // flush coinciding with an output handshake
    add(1, 32'h11, 1, 0, 1, 0, 0); add(0, JUNK, 1, 0, 1, 0, 1); add(0, JUNK, 1, 0, 1, 0, 1);
    add(1, 32'h88, 1, 1, 0, 1, 1); add(0, JUNK, 1, 0, 1, 0, 0, 1);
    // full with simultaneous enqueue and dequeue
    add(1, 32'h21, 0, 0, 1, 0, 0); add(1, 32'h22, 0, 0, 1, 0, 1); add(1, 32'h23, 0, 0, 1, 0, 2);
    add(1, 32'h24, 1, 0, 1, 1, 3); add(1, 32'h25, 1, 0, 1, 1, 3); add(0, JUNK, 0, 0, 0, 1, 3);
    add(0, JUNK, 1, 0, 1, 1, 3); add(0, JUNK, 1, 0, 1, 1, 2); add(0, JUNK, 1, 0, 1, 1, 1);
    add(0, JUNK, 1, 0, 1, 0, 0);
    // fill before the asynchronous reset
    add(1, 32'h31, 0, 0, 1, 0, 0); add(1, 32'h32, 0, 0, 1, 0, 1); add(1, 32'h33, 0, 0, 1, 0, 2);
    add(0, JUNK, 0, 0, 0, 1, 3);
    run_vecs();

    // asynchronous reset between edges while full
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_out_data", out_data, RST_V);
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("arst_in_ready", 32'(in_ready), 32'd1);

    add(1, 32'h41, 1, 0, 1, 0, 0); add(1, 32'h42, 1, 0, 1, 0, 1); add(0, JUNK, 1, 0, 1, 0, 2);
    add(0, JUNK, 1, 0, 1, 1, 2); add(0, JUNK, 1, 0, 1, 1, 1); add(0, JUNK, 1, 0, 1, 0, 0);
    run_vecs();

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
